// File: rtl/audio_sram_arbiter_if.sv
// Bus between the audio SRAM arbiter, its three requesters and the SRAM read port.
// The arbiter connects through the slave modport. The requester/SRAM side uses master.
interface audio_sram_arbiter_if #(
   parameter int AW = 15
);
   logic [2:0]    req;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [2:0]    gnt;
   logic [2:0]    rvalid;
   logic [31:0]   rdata;
   logic [AW-1:0] sram_addra;
   logic          sram_ena;
   logic [31:0]   sram_douta;

   modport master (
      output req, addr0, addr1, addr2, sram_douta,
      input  gnt, rvalid, rdata, sram_addra, sram_ena
   );

   modport slave (
      input  req, addr0, addr1, addr2, sram_douta,
      output gnt, rvalid, rdata, sram_addra, sram_ena
   );
endinterface

// File: rtl/audio_sram_arbiter.sv
// Three-way rotating-priority arbiter for the audio sample SRAM read port, with a return pipeline.
// Defining AUDIO_ARB_MUSIC_PRIO_EN gives requester 0 strict priority; requesters 1 and 2 then rotate.
module audio_sram_arbiter #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = 15
) (
   input logic                clk,
   input logic                rst,
   audio_sram_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      PTR0 = 3'b001,
      PTR1 = 3'b010,
      PTR2 = 3'b100
   } ptr_t;

   ptr_t          ptr;
   ptr_t          ptr_nxt;
   logic [2:0]    elig;
   logic [2:0]    win;
   logic [AW-1:0] win_addr;
   logic [2:0]    pipe [RD_LAT];

   // The requester granted this cycle sits out one arbitration round.
   assign elig = bus.req & ~bus.gnt;

   always_comb begin
      win     = '0;
      ptr_nxt = ptr;
`ifdef AUDIO_ARB_MUSIC_PRIO_EN
      if (elig[0])
         win = 3'b001;
      else if (ptr == PTR2) begin
         if (elig[2])      win = 3'b100;
         else if (elig[1]) win = 3'b010;
      end else begin
         if (elig[1])      win = 3'b010;
         else if (elig[2]) win = 3'b100;
      end
      case (win)
         3'b010:  ptr_nxt = PTR2;
         3'b100:  ptr_nxt = PTR1;
         default: ptr_nxt = ptr;
      endcase
`else
      case (ptr)
         PTR0: begin
            if (elig[0])      win = 3'b001;
            else if (elig[1]) win = 3'b010;
            else if (elig[2]) win = 3'b100;
         end
         PTR1: begin
            if (elig[1])      win = 3'b010;
            else if (elig[2]) win = 3'b100;
            else if (elig[0]) win = 3'b001;
         end
         PTR2: begin
            if (elig[2])      win = 3'b100;
            else if (elig[0]) win = 3'b001;
            else if (elig[1]) win = 3'b010;
         end
         default: win = '0;
      endcase
      case (win)
         3'b001:  ptr_nxt = PTR1;
         3'b010:  ptr_nxt = PTR2;
         3'b100:  ptr_nxt = PTR0;
         default: ptr_nxt = ptr;
      endcase
`endif
   end

   always_comb begin
      case (win)
         3'b010:  win_addr = bus.addr1;
         3'b100:  win_addr = bus.addr2;
         default: win_addr = bus.addr0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.gnt        <= '0;
         bus.sram_ena   <= 1'b0;
         bus.sram_addra <= '0;
         bus.rvalid     <= '0;
         bus.rdata      <= '0;
         ptr            <= PTR0;
         for (int unsigned i = 0; i < RD_LAT; i++)
            pipe[i] <= '0;
      end else begin
         bus.gnt      <= win;
         bus.sram_ena <= |win;
         if (|win)
            bus.sram_addra <= win_addr;
         ptr <= ptr_nxt;
         // Grant one-hot doubles as {valid, id}; it emerges when the SRAM word is ready.
         pipe[0] <= bus.gnt;
         for (int unsigned i = 1; i < RD_LAT; i++)
            pipe[i] <= pipe[i-1];
         bus.rvalid <= pipe[RD_LAT-1];
         if (|pipe[RD_LAT-1])
            bus.rdata <= bus.sram_douta;
      end
   end
endmodule

// File: tb/tb_audio_sram_arbiter.sv
// Directed bench for audio_sram_arbiter with a behavioural single-cycle SRAM and a read-return scoreboard.
module tb_audio_sram_arbiter;
   localparam int unsigned RD_LAT = 1;
   localparam int unsigned AW     = 15;

   typedef struct {
      logic [2:0]  id;
      logic [31:0] data;
      int unsigned due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   dq;
   logic [AW-1:0] a [3];
   exp_t          sb [$];
   int            checks = 0;
   int            errors = 0;
   int unsigned   cyc = 0;

   audio_sram_arbiter_if #(.AW(AW)) bus ();

   audio_sram_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] ad);
      if (ad == 15'h0010) return 32'h11223344;
      return {17'h1A5A5, ad};
   endfunction

   always @(posedge clk)
      if (bus.sram_ena) dq <= mem_word(bus.sram_addra);
   assign bus.sram_douta = dq;

   function automatic int exp_w(input int k);
`ifdef AUDIO_ARB_MUSIC_PRIO_EN
      if (k % 2 == 0) return 0;
      return (k % 4 == 1) ? 1 : 2;
`else
      return k % 3;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_addrs();
      bus.addr0 = a[0];
      bus.addr1 = a[1];
      bus.addr2 = a[2];
   endtask

   task automatic push(input int w);
      exp_t e;
      e.id   = 3'(1 << w);
      e.data = mem_word(a[w]);
      e.due  = cyc + 2;
      sb.push_back(e);
   endtask

   // Advance one clock and sample just after the edge; retire returned words against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rvalid != 3'b000) begin
         if (sb.size() == 0)
            chk("unexpected_rvalid", 32'(bus.rvalid), 32'h0);
         else begin
            e = sb.pop_front();
            chk("rvalid_id", 32'(bus.rvalid), 32'(e.id));
            chk("rdata", bus.rdata, e.data);
            chk("latency", cyc, e.due);
         end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("missing_rvalid", 32'(bus.rvalid), 32'(e.id));
      end
   endtask

   initial begin
      int w;
      logic [2:0] prev;
      rst     = 1'b1;
      bus.req = 3'b111;
      a[0] = 15'h0100; a[1] = 15'h0200; a[2] = 15'h0300;
      drive_addrs();

      // Reset with all requests pending
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_gnt", 32'(bus.gnt), 32'h0);
         chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
         chk("rst_rdata", bus.rdata, 32'h0);
         chk("rst_addra", 32'(bus.sram_addra), 32'h0);
         chk("rst_ena", 32'(bus.sram_ena), 32'h0);
      end
      rst = 1'b0;

      // Contention: all held, each granted requester moves to a new address
      prev = 3'b000;
      for (int k = 0; k < 6; k++) begin
         w = exp_w(k);
         tick();
         chk("cont_gnt", 32'(bus.gnt), 32'(1) << w);
         chk("cont_addra", 32'(bus.sram_addra), 32'(a[w]));
         chk("cont_ena", 32'(bus.sram_ena), 32'h1);
         chk("cont_no_repeat", 32'(bus.gnt & prev), 32'h0);
         prev = bus.gnt;
         push(w);
         a[w] = a[w] + 15'h0003;
         drive_addrs();
      end
      bus.req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drain_gnt", 32'(bus.gnt), 32'h0);
         chk("drain_ena", 32'(bus.sram_ena), 32'h0);
      end

      // Withdrawal: requester 2 loses to 0 and drops its request
      bus.req = 3'b101;
      tick();
      chk("wd_gnt", 32'(bus.gnt), 32'h1);
      push(0);
      bus.req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wd_idle_gnt", 32'(bus.gnt), 32'h0);
         chk("wd_idle_ena", 32'(bus.sram_ena), 32'h0);
      end

      // Single fetch of a known word
      a[0] = 15'h0010;
      drive_addrs();
      bus.req = 3'b001;
      tick();
      chk("single_gnt", 32'(bus.gnt), 32'h1);
      chk("single_addra", 32'(bus.sram_addra), 32'h0010);
      push(0);
      bus.req = 3'b000;
      tick();
      chk("single_idle_ena", 32'(bus.sram_ena), 32'h0);
      tick();
      tick();
      chk("rdata_held", bus.rdata, 32'h11223344);
      chk("rvalid_pulse", 32'(bus.rvalid), 32'h0);

      // Reset the cycle after a grant to requester 1: that fetch must never return
      bus.req = 3'b010;
      tick();
      chk("mid_gnt", 32'(bus.gnt), 32'h2);
      rst = 1'b1;
      bus.req = 3'b000;
      tick();
      chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
      chk("mid_rst_ena", 32'(bus.sram_ena), 32'h0);
      chk("mid_rst_rdata", bus.rdata, 32'h0);
      chk("mid_rst_addra", 32'(bus.sram_addra), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      bus.req = 3'b111;
      tick();
      chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
      push(0);
      bus.req = 3'b000;
      for (int i = 0; i < 3; i++) tick();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
